cdb_result_broadcaster: RTL and testbench

- Producer end of the wake-up protocol. Reservation-station entries wait on Qj/Qk/Ql/Qm tags and clear when a matching ROB tag is broadcast.
- Accepts results from one functional unit (ALU or LSU) and buffers them in an in-order FIFO.
- Presents the FIFO head on the common data bus (CDB) under an external grant handshake.
- Tag 0 means "no dependency" codebase-wide, so this block never broadcasts it.

---
 rtl/cdb_result_broadcaster.sv | 132 +++++++++++++
 tb/tb_cdb_result_broadcaster.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_result_broadcaster.sv
// -----------------------------------------------------------------------------
// cdb_result_broadcaster
//
// Producer end of the wake-up protocol. Results from one functional unit are
// queued in an in-order FIFO and the head entry is offered on the common data
// bus under an external grant handshake. ROB tag 0 means "no dependency", so
// tag-0 results are never queued; they are counted in a saturating counter.
//
// Optional feature (macro CDB_BYPASS_EN): when the FIFO is empty, a valid
// result with a non-zero tag is shown on the CDB in the same cycle. If it is
// granted in that cycle it is consumed without being written to the FIFO.
//
// Ports:
//   clk_in      clock
//   rst_in      asynchronous active-high reset
//   rdy_in      global clock enable, all state holds while low
//   flush_in    synchronous clear of the FIFO (qualified by rdy_in)
//   fu_valid    functional unit presents a result
//   fu_rob_id   destination ROB tag of the result
//   fu_value    result value
//   fu_ready    block can accept a result this cycle
//   cdb_valid   broadcast request
//   cdb_rob_id  broadcast tag
//   cdb_value   broadcast value
//   cdb_grant   arbiter grants the bus this cycle
//   drop_count  saturating count of discarded tag-0 results
// -----------------------------------------------------------------------------
module cdb_result_broadcaster #(
    parameter int ROB_W  = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              fu_valid,
    input  logic [ROB_W-1:0]  fu_rob_id,
    input  logic [DATA_W-1:0] fu_value,
    output logic              fu_ready,
    output logic              cdb_valid,
    output logic [ROB_W-1:0]  cdb_rob_id,
    output logic [DATA_W-1:0] cdb_value,
    input  logic              cdb_grant,
    output logic [7:0]        drop_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ROB_W-1:0]  r_rob_mem [DEPTH];
    logic [DATA_W-1:0] r_val_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [7:0]        r_drop;

    logic w_empty;
    logic w_tag_ok;
    logic w_accept;
    logic w_bypass;
    logic w_push;
    logic w_pop;
    logic w_drop;

    assign w_empty  = (r_count == '0);
    assign w_tag_ok = (fu_rob_id != '0);

    // fu_ready depends on the count register only, so a pop in the same
    // cycle as full does not open the input until the following cycle.
    assign fu_ready = (r_count != FULL_CNT);
    assign w_accept = fu_valid & fu_ready;

`ifdef CDB_BYPASS_EN
    assign w_bypass = w_empty & fu_valid & w_tag_ok & ~flush_in;
`else
    assign w_bypass = 1'b0;
`endif

    // A granted bypass result is consumed straight off the FU inputs and
    // must not also land in the FIFO.
    assign w_push = rdy_in & ~flush_in & w_accept & w_tag_ok & ~(w_bypass & cdb_grant);
    assign w_pop  = rdy_in & ~flush_in & ~w_empty & cdb_grant;
    assign w_drop = rdy_in & w_accept & ~w_tag_ok;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
            if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
        end
    end

    // Storage needs no reset: the outputs are masked whenever count is zero.
    always_ff @(posedge clk_in) begin
        if (w_push && !rst_in) begin
            r_rob_mem[r_wr_ptr] <= fu_rob_id;
            r_val_mem[r_wr_ptr] <= fu_value;
        end
    end

    always_comb begin
        cdb_valid  = 1'b0;
        cdb_rob_id = '0;
        cdb_value  = '0;
        if (!w_empty) begin
            cdb_valid  = 1'b1;
            cdb_rob_id = r_rob_mem[r_rd_ptr];
            cdb_value  = r_val_mem[r_rd_ptr];
        end else if (w_bypass) begin
            cdb_valid  = 1'b1;
            cdb_rob_id = fu_rob_id;
            cdb_value  = fu_value;
        end
    end

    assign drop_count = r_drop;

endmodule

// File: tb/tb_cdb_result_broadcaster.sv
module tb_cdb_result_broadcaster;

    localparam int DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        fu_valid;
    logic [3:0]  fu_rob_id;
    logic [31:0] fu_value;
    logic        fu_ready;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_value;
    logic        cdb_grant;
    logic [7:0]  drop_count;

    int n_cmp  = 0;
    int n_fail = 0;

    cdb_result_broadcaster #(.ROB_W(4), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush_in   (flush_in),
        .fu_valid   (fu_valid),
        .fu_rob_id  (fu_rob_id),
        .fu_value   (fu_value),
        .fu_ready   (fu_ready),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_value  (cdb_value),
        .cdb_grant  (cdb_grant),
        .drop_count (drop_count)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- reference model: a queue of pending results ----------
    typedef struct packed {
        logic [3:0]  rob;
        logic [31:0] val;
    } ent_t;

    typedef struct packed {
        logic        rdy;
        logic        flush;
        logic        fv;
        logic [3:0]  rob;
        logic [31:0] val;
        logic        grant;
    } step_t;

    ent_t       q[$];
    logic [7:0] m_drop = 8'd0;

    logic        ev, efr;
    logic [3:0]  er;
    logic [31:0] ed;

    function automatic step_t mk(logic rdy, logic flush, logic fv, logic [3:0] rob,
                                 logic [31:0] val, logic grant);
        step_t s;
        s.rdy = rdy; s.flush = flush; s.fv = fv; s.rob = rob; s.val = val; s.grant = grant;
        return s;
    endfunction

    task automatic drive(input step_t s);
        rdy_in    = s.rdy;
        flush_in  = s.flush;
        fu_valid  = s.fv;
        fu_rob_id = s.rob;
        fu_value  = s.val;
        cdb_grant = s.grant;
    endtask

    function automatic void model_out();
        ev  = (q.size() != 0);
        er  = ev ? q[0].rob : 4'd0;
        ed  = ev ? q[0].val : 32'd0;
        efr = (q.size() < DEPTH);
`ifdef CDB_BYPASS_EN
        if (q.size() == 0 && fu_valid && fu_rob_id != 4'd0 && !flush_in) begin
            ev = 1'b1;
            er = fu_rob_id;
            ed = fu_value;
        end
`endif
    endfunction

    // Advance the model with the inputs currently applied, then clock once.
    task automatic tick();
        bit acc, consumed, do_push;
        ent_t e;
        if (rdy_in && !rst_in) begin
            acc = fu_valid && (q.size() < DEPTH);
            if (acc && fu_rob_id == 4'd0 && m_drop != 8'd255) m_drop = m_drop + 8'd1;
            if (flush_in) begin
                q.delete();
            end else begin
                consumed = 0;
`ifdef CDB_BYPASS_EN
                if (q.size() == 0 && fu_valid && fu_rob_id != 4'd0 && cdb_grant) consumed = 1;
`endif
                do_push = acc && fu_rob_id != 4'd0 && !consumed;
                if (q.size() > 0 && cdb_grant) void'(q.pop_front());
                if (do_push) begin
                    e.rob = fu_rob_id;
                    e.val = fu_value;
                    q.push_back(e);
                end
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    // ---------------- tests -------------------------------------------------
    task automatic test_reset();
        drive(mk(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0));
        rst_in = 1'b1;
        #1;
        n_cmp++;
        if ({cdb_valid, fu_ready, drop_count, cdb_rob_id, cdb_value} !== {1'b0, 1'b1, 8'd0, 4'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_initial: got v=%b rdy=%b drop=%0d tag=%0d val=%h, want v=0 rdy=1 drop=0 tag=0 val=0",
                     cdb_valid, fu_ready, drop_count, cdb_rob_id, cdb_value);
        end
        tick(); tick();
        rst_in = 1'b0;
        q.delete(); m_drop = 8'd0;
        // put some state in, then reset in the middle of a cycle
        drive(mk(1'b1, 1'b0, 1'b1, 4'd2, 32'h55, 1'b0)); tick();
        drive(mk(1'b1, 1'b0, 1'b1, 4'd0, 32'h66, 1'b0)); tick();
        drive(mk(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0));
        #1;
        n_cmp++;
        if ({cdb_valid, cdb_rob_id, drop_count} !== {1'b1, 4'd2, 8'd1}) begin
            n_fail++;
            $display("FAIL reset_preload: got v=%b tag=%0d drop=%0d, want v=1 tag=2 drop=1",
                     cdb_valid, cdb_rob_id, drop_count);
        end
        #2;
        rst_in = 1'b1;
        #1;
        n_cmp++;
        if ({cdb_valid, fu_ready, drop_count, cdb_rob_id, cdb_value} !== {1'b0, 1'b1, 8'd0, 4'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_midcycle: got v=%b rdy=%b drop=%0d tag=%0d val=%h, want v=0 rdy=1 drop=0 tag=0 val=0",
                     cdb_valid, fu_ready, drop_count, cdb_rob_id, cdb_value);
        end
        q.delete(); m_drop = 8'd0;
        tick();
        rst_in = 1'b0;
    endtask

    task automatic test_order();
        step_t s[5];
        s[0] = mk(1'b1, 1'b0, 1'b1, 4'd3, 32'h11, 1'b1);
        s[1] = mk(1'b1, 1'b0, 1'b1, 4'd5, 32'h22, 1'b1);
        s[2] = mk(1'b1, 1'b0, 1'b0, 4'd0, 32'h0,  1'b1);
        s[3] = mk(1'b1, 1'b0, 1'b0, 4'd0, 32'h0,  1'b1);
        s[4] = mk(1'b1, 1'b0, 1'b0, 4'd0, 32'h0,  1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(s[i]); #1;
            model_out();
            n_cmp++;
            if ({cdb_valid, cdb_rob_id, cdb_value, fu_ready, drop_count} !== {ev, er, ed, efr, m_drop}) begin
                n_fail++;
                $display("FAIL order step %0d: got v=%b tag=%0d val=%h rdy=%b drop=%0d, want v=%b tag=%0d val=%h rdy=%b drop=%0d",
                         i, cdb_valid, cdb_rob_id, cdb_value, fu_ready, drop_count, ev, er, ed, efr, m_drop);
            end
            tick();
        end
        n_cmp++;
        if (cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL order_drained: got v=%b, want v=0", cdb_valid);
        end
    endtask

    task automatic test_full();
        step_t s[7];
        for (int i = 0; i < 4; i++) s[i] = mk(1'b1, 1'b0, 1'b1, 4'(i + 1), 32'h100 + 32'(i), 1'b0);
        s[4] = mk(1'b1, 1'b0, 1'b1, 4'd6, 32'h106, 1'b0);
        s[5] = mk(1'b1, 1'b0, 1'b0, 4'd0, 32'h0,   1'b1);
        s[6] = mk(1'b1, 1'b0, 1'b0, 4'd0, 32'h0,   1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(s[i]); #1;
            model_out();
            n_cmp++;
            if ({cdb_valid, cdb_rob_id, cdb_value, fu_ready, drop_count} !== {ev, er, ed, efr, m_drop}) begin
                n_fail++;
                $display("FAIL full step %0d: got v=%b tag=%0d val=%h rdy=%b drop=%0d, want v=%b tag=%0d val=%h rdy=%b drop=%0d",
                         i, cdb_valid, cdb_rob_id, cdb_value, fu_ready, drop_count, ev, er, ed, efr, m_drop);
            end
            if (i == 4) begin
                n_cmp++;
                if ({fu_ready, cdb_rob_id} !== {1'b0, 4'd1}) begin
                    n_fail++;
                    $display("FAIL full_blocked: got rdy=%b tag=%0d, want rdy=0 tag=1", fu_ready, cdb_rob_id);
                end
            end
            if (i == 5) begin
                n_cmp++;
                if (fu_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_pop_same_cycle: got rdy=%b, want rdy=0", fu_ready);
                end
            end
            tick();
        end
        n_cmp++;
        if ({fu_ready, cdb_rob_id, cdb_value} !== {1'b1, 4'd2, 32'h101}) begin
            n_fail++;
            $display("FAIL full_after_pop: got rdy=%b tag=%0d val=%h, want rdy=1 tag=2 val=101",
                     fu_ready, cdb_rob_id, cdb_value);
        end
    endtask

    task automatic test_simul();
        step_t s[6];
        s[0] = mk(1'b1, 1'b0, 1'b1, 4'd7, 32'h207, 1'b1);
        s[1] = mk(1'b1, 1'b0, 1'b1, 4'd8, 32'h208, 1'b1);
        s[2] = mk(1'b1, 1'b0, 1'b1, 4'd0, 32'h2FF, 1'b0);
        s[3] = mk(1'b1, 1'b0, 1'b0, 4'd0, 32'h0,   1'b1);
        s[4] = mk(1'b1, 1'b0, 1'b0, 4'd0, 32'h0,   1'b1);
        s[5] = mk(1'b1, 1'b0, 1'b0, 4'd0, 32'h0,   1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(s[i]); #1;
            model_out();
            n_cmp++;
            if ({cdb_valid, cdb_rob_id, cdb_value, fu_ready, drop_count} !== {ev, er, ed, efr, m_drop}) begin
                n_fail++;
                $display("FAIL simul step %0d: got v=%b tag=%0d val=%h rdy=%b drop=%0d, want v=%b tag=%0d val=%h rdy=%b drop=%0d",
                         i, cdb_valid, cdb_rob_id, cdb_value, fu_ready, drop_count, ev, er, ed, efr, m_drop);
            end
            if (i == 3) begin
                n_cmp++;
                if ({cdb_rob_id, fu_ready, drop_count} !== {4'd4, 1'b1, 8'd1}) begin
                    n_fail++;
                    $display("FAIL simul_count3_drop: got tag=%0d rdy=%b drop=%0d, want tag=4 rdy=1 drop=1",
                             cdb_rob_id, fu_ready, drop_count);
                end
            end
            tick();
        end
        n_cmp++;
        if (cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_drained: got v=%b, want v=0", cdb_valid);
        end
    endtask

    task automatic test_flush_stall();
        step_t s[14];
        for (int i = 0; i < 3; i++) s[i] = mk(1'b1, 1'b0, 1'b1, 4'(i + 1), 32'h300 + 32'(i), 1'b0);
        s[3] = mk(1'b1, 1'b1, 1'b1, 4'd7, 32'h307, 1'b1);
        s[4] = mk(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
        s[5] = mk(1'b1, 1'b0, 1'b1, 4'd10, 32'h30A, 1'b0);
        s[6] = mk(1'b1, 1'b0, 1'b1, 4'd11, 32'h30B, 1'b0);
        for (int i = 7; i < 12; i++) s[i] = mk(1'b0, 1'b0, 1'b1, 4'd12, 32'h30C, 1'b1);
        s[12] = mk(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1);
        s[13] = mk(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1);
        for (int i = 0; i < 14; i++) begin
            drive(s[i]); #1;
            model_out();
            n_cmp++;
            if ({cdb_valid, cdb_rob_id, cdb_value, fu_ready, drop_count} !== {ev, er, ed, efr, m_drop}) begin
                n_fail++;
                $display("FAIL flush step %0d: got v=%b tag=%0d val=%h rdy=%b drop=%0d, want v=%b tag=%0d val=%h rdy=%b drop=%0d",
                         i, cdb_valid, cdb_rob_id, cdb_value, fu_ready, drop_count, ev, er, ed, efr, m_drop);
            end
            if (i == 4) begin
                n_cmp++;
                if ({cdb_valid, fu_ready, drop_count} !== {1'b0, 1'b1, 8'd1}) begin
                    n_fail++;
                    $display("FAIL flush_cleared: got v=%b rdy=%b drop=%0d, want v=0 rdy=1 drop=1",
                             cdb_valid, fu_ready, drop_count);
                end
            end
            if (i >= 7 && i < 12) begin
                n_cmp++;
                if ({cdb_valid, cdb_rob_id, cdb_value} !== {1'b1, 4'd10, 32'h30A}) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc %0d: got v=%b tag=%0d val=%h, want v=1 tag=10 val=30a",
                             i, cdb_valid, cdb_rob_id, cdb_value);
                end
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        drive(mk(1'b1, 1'b0, 1'b1, 4'd9, 32'hAB, 1'b1)); #1;
        n_cmp++;
`ifdef CDB_BYPASS_EN
        if ({cdb_valid, cdb_rob_id, cdb_value} !== {1'b1, 4'd9, 32'hAB}) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: got v=%b tag=%0d val=%h, want v=1 tag=9 val=ab",
                     cdb_valid, cdb_rob_id, cdb_value);
        end
`else
        if (cdb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL nobypass_same_cycle: got v=%b, want v=0", cdb_valid);
        end
`endif
        tick();
        drive(mk(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0)); #1;
        n_cmp++;
`ifdef CDB_BYPASS_EN
        if ({cdb_valid, fu_ready} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL bypass_no_write: got v=%b rdy=%b, want v=0 rdy=1", cdb_valid, fu_ready);
        end
`else
        if ({cdb_valid, cdb_rob_id, cdb_value} !== {1'b1, 4'd9, 32'hAB}) begin
            n_fail++;
            $display("FAIL nobypass_next_cycle: got v=%b tag=%0d val=%h, want v=1 tag=9 val=ab",
                     cdb_valid, cdb_rob_id, cdb_value);
        end
`endif
        drive(mk(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1));
        tick();
    endtask

    task automatic test_random();
        step_t s;
        int gbias;
        for (int i = 0; i < 400; i++) begin
            gbias = (i < 200) ? 1 : 3;
            s.rdy   = ($urandom_range(0, 7) != 0);
            s.flush = ($urandom_range(0, 39) == 0);
            s.fv    = ($urandom_range(0, 3) != 0);
            s.rob   = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            s.val   = $urandom;
            s.grant = ($urandom_range(0, 3) < gbias);
            drive(s); #1;
            model_out();
            n_cmp++;
            if ({cdb_valid, cdb_rob_id, cdb_value, fu_ready, drop_count} !== {ev, er, ed, efr, m_drop}) begin
                n_fail++;
                $display("FAIL random cyc %0d: got v=%b tag=%0d val=%h rdy=%b drop=%0d, want v=%b tag=%0d val=%h rdy=%b drop=%0d",
                         i, cdb_valid, cdb_rob_id, cdb_value, fu_ready, drop_count, ev, er, ed, efr, m_drop);
            end
            tick();
        end
    endtask

    task automatic test_drop_saturate();
        drive(mk(1'b1, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0));
        tick();
        drive(mk(1'b1, 1'b0, 1'b1, 4'd0, 32'hDEAD, 1'b0));
        for (int i = 0; i < 270; i++) tick();
        n_cmp++;
        if ({drop_count, cdb_valid} !== {8'd255, 1'b0}) begin
            n_fail++;
            $display("FAIL drop_saturate: got drop=%0d v=%b, want drop=255 v=0", drop_count, cdb_valid);
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_full();
        test_simul();
        test_flush_stall();
        test_bypass();
        test_random();
        test_drop_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
